oam_evaluator: RTL

OAM_EVALUATOR -- requirements
Module: oam_evaluator

---
 rtl/oam_evaluator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/oam_evaluator.sv
// -----------------------------------------------------------------------------
// oam_evaluator
//
// Per-scanline sprite evaluation. During horizontal blanking the block walks
// every OAM entry in ascending order, tests whether the sprite covers the next
// scanline, and copies up to CACHE_DEPTH hits into a line cache. The line
// result (hit count and overflow flag) is committed once at the end of the
// scan. The scan is aborted if active display resumes before it finishes.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset
//   line_start   single-cycle pulse at start of horizontal blanking
//   next_y       scanline to evaluate, sampled on an accepted line_start
//   video_on     active-display indicator; high during a scan aborts it
//   oam_addr     OAM read address (synchronous OAM, data one cycle later)
//   oam_data     OAM read data: [31] enable, [15:6] pos_y
//   cache_we     line-cache write strobe
//   cache_waddr  line-cache write index
//   cache_wdata  OAM word written to the line cache, unmodified
//   cache_count  number of valid cache entries for the committed line
//   overflow     more than CACHE_DEPTH sprites hit the committed line
//   busy         scan in progress (SCAN or DONE)
//   done         single-cycle pulse when a scan completes
// -----------------------------------------------------------------------------
module oam_evaluator #(
    parameter int OAM_DEPTH   = 8,
    parameter int OAM_WIDTH   = 32,
    parameter int CACHE_DEPTH = 4,
    parameter int TILE_HEIGHT = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           line_start,
    input  logic [9:0]                     next_y,
    input  logic                           video_on,
    output logic [$clog2(OAM_DEPTH)-1:0]   oam_addr,
    input  logic [OAM_WIDTH-1:0]           oam_data,
    output logic                           cache_we,
    output logic [$clog2(CACHE_DEPTH)-1:0] cache_waddr,
    output logic [OAM_WIDTH-1:0]           cache_wdata,
    output logic [$clog2(CACHE_DEPTH):0]   cache_count,
    output logic                           overflow,
    output logic                           busy,
    output logic                           done
);

    localparam int AW = $clog2(OAM_DEPTH);
    localparam int CW = $clog2(CACHE_DEPTH);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(OAM_DEPTH - 1);
    localparam logic [AW:0]   SCAN_LAST  = (AW + 1)'(OAM_DEPTH);
    localparam logic [CW:0]   CACHE_FULL = (CW + 1)'(CACHE_DEPTH);
    localparam logic [10:0]   TILE_H11   = 11'(TILE_HEIGHT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [9:0]  target_y;
    logic [CW:0] work_cnt;
    logic        work_ovf;
    // Counts SCAN cycles. Value 0 is the cycle in which address 0 is only
    // being presented; from 1 onward oam_data holds entry scan_cnt-1.
    logic [AW:0] scan_cnt;

    // Range test in 11 bits so pos_y + TILE_HEIGHT never wraps back into
    // low scanlines.
    logic [10:0] pos_y11;
    logic [10:0] tgt_y11;
    logic        in_range;

    assign pos_y11  = {1'b0, oam_data[15:6]};
    assign tgt_y11  = {1'b0, target_y};
    assign in_range = oam_data[31] && (pos_y11 <= tgt_y11) &&
                      (tgt_y11 < (pos_y11 + TILE_H11));

    // NOTE: all state and outputs are updated with non-blocking assignments
    // in one clocked process so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            oam_addr    <= '0;
            cache_we    <= 1'b0;
            cache_waddr <= '0;
            cache_wdata <= '0;
            cache_count <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            target_y    <= '0;
            work_cnt    <= '0;
            work_ovf    <= 1'b0;
            scan_cnt    <= '0;
        end else begin
            // Strobes default low and are raised only in the cycle they apply.
            cache_we <= 1'b0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (line_start && !video_on) begin
                        target_y <= next_y;
                        work_cnt <= '0;
                        work_ovf <= 1'b0;
                        oam_addr <= '0;
                        scan_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end

                SCAN: begin
                    if (video_on) begin
                        // Abort: discard the partial result entirely.
                        cache_count <= '0;
                        overflow    <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        if (oam_addr != LAST_ADDR) begin
                            oam_addr <= oam_addr + 1'b1;
                        end
                        scan_cnt <= scan_cnt + 1'b1;

                        if (scan_cnt != '0) begin
                            if (in_range) begin
                                if (work_cnt < CACHE_FULL) begin
                                    cache_we    <= 1'b1;
                                    cache_waddr <= work_cnt[CW-1:0];
                                    cache_wdata <= oam_data;
                                    work_cnt    <= work_cnt + 1'b1;
                                end else begin
                                    work_ovf <= 1'b1;
                                end
                            end
                            if (scan_cnt == SCAN_LAST) begin
                                state <= DONE;
                            end
                        end
                    end
                end

                DONE: begin
                    done        <= 1'b1;
                    cache_count <= work_cnt;
                    overflow    <= work_ovf;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
